// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline with decode-stage branch resolution:
// forwarding selects, load-use / branch stalls and a saturating stall counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  WriteRegD,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        BranchD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [15:0] StallCnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [4:0]  r_RsE;
    logic [4:0]  r_RtE;
    logic [4:0]  r_WriteRegE;
    logic        r_RegWriteE;
    logic        r_MemtoRegE;
    logic [4:0]  r_WriteRegM;
    logic        r_RegWriteM;
    logic        r_MemtoRegM;
    logic [4:0]  r_WriteRegW;
    logic        r_RegWriteW;
    logic [15:0] r_StallCnt;

    logic        w_lwstall;
    logic        w_branchstall;
    logic        w_stall;

    // M has priority over W because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       regwrite_m,
        input logic [4:0] writereg_m,
        input logic       regwrite_w,
        input logic [4:0] writereg_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0 && regwrite_m && writereg_m == src)
            sel = 2'd2;
        else if (src != 5'd0 && regwrite_w && writereg_w == src)
            sel = 2'd1;
        return sel;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(r_RsE, r_RegWriteM, r_WriteRegM, r_RegWriteW, r_WriteRegW);
        ForwardBE = fwd_sel(r_RtE, r_RegWriteM, r_WriteRegM, r_RegWriteW, r_WriteRegW);
        ForwardAD = (RsD != 5'd0) && r_RegWriteM && (r_WriteRegM == RsD);
        ForwardBD = (RtD != 5'd0) && r_RegWriteM && (r_WriteRegM == RtD);
    end

    // Register 0 is not excluded here; a spurious stall on r0 costs one cycle only.
    always_comb begin
        w_lwstall     = r_MemtoRegE && (r_RtE == RsD || r_RtE == RtD);
        w_branchstall = BranchD &&
                        ((r_RegWriteE && (r_WriteRegE == RsD || r_WriteRegE == RtD)) ||
                         (r_MemtoRegM && (r_WriteRegM == RsD || r_WriteRegM == RtD)));
        w_stall       = w_lwstall || w_branchstall;
    end

    assign StallF   = w_stall;
    assign StallD   = w_stall;
    assign FlushE   = w_stall;
    assign StallCnt = r_StallCnt;

    // D -> E: a stall turns the E slot into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_RsE       <= 5'd0;
            r_RtE       <= 5'd0;
            r_WriteRegE <= 5'd0;
            r_RegWriteE <= 1'b0;
            r_MemtoRegE <= 1'b0;
        end else if (w_stall) begin
            r_RsE       <= 5'd0;
            r_RtE       <= 5'd0;
            r_WriteRegE <= 5'd0;
            r_RegWriteE <= 1'b0;
            r_MemtoRegE <= 1'b0;
        end else begin
            r_RsE       <= RsD;
            r_RtE       <= RtD;
            r_WriteRegE <= WriteRegD;
            r_RegWriteE <= RegWriteD;
            r_MemtoRegE <= MemtoRegD;
        end
    end

    // E -> M -> W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_WriteRegM <= 5'd0;
            r_RegWriteM <= 1'b0;
            r_MemtoRegM <= 1'b0;
            r_WriteRegW <= 5'd0;
            r_RegWriteW <= 1'b0;
        end else begin
            r_WriteRegM <= r_WriteRegE;
            r_RegWriteM <= r_RegWriteE;
            r_MemtoRegM <= r_MemtoRegE;
            r_WriteRegW <= r_WriteRegM;
            r_RegWriteW <= r_RegWriteM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_StallCnt <= 16'd0;
        else if (w_stall && r_StallCnt != CNT_MAX)
            r_StallCnt <= r_StallCnt + 16'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stalls, stall counter and reset.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  WriteRegD;
    logic        RegWriteD;
    logic        MemtoRegD;
    logic        BranchD;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        ForwardAD;
    logic        ForwardBD;
    logic        StallF;
    logic        StallD;
    logic        FlushE;
    logic [15:0] StallCnt;

    int          checks;
    int          errors;
    logic [15:0] exp_cnt;

    hazard_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RsD       (RsD),
        .RtD       (RtD),
        .WriteRegD (WriteRegD),
        .RegWriteD (RegWriteD),
        .MemtoRegD (MemtoRegD),
        .BranchD   (BranchD),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .StallCnt  (StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic rw, input logic mtr, input logic br);
        RsD       = rs;
        RtD       = rt;
        WriteRegD = wr;
        RegWriteD = rw;
        MemtoRegD = mtr;
        BranchD   = br;
        #1;
    endtask

    task automatic flush_pipe;
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_d(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0",
                     {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE});
        end
        checks++;
        if (StallCnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0h exp 0", StallCnt);
        end
        repeat (2) tick();
        checks++;
        if ({StallF, ForwardAD, ForwardBD} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held got %b exp 000", {StallF, ForwardAD, ForwardBD});
        end
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        // First edge loads the load-to-r3 into E; D is a branch on r3.
        tick();
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            errors++;
            $display("FAIL first_edge_stall got %b exp 111", {StallF, StallD, FlushE});
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (StallCnt !== exp_cnt || StallF !== 1'b1) begin
            errors++;
            $display("FAIL single_count got cnt=%0d stall=%b exp cnt=%0d stall=1", StallCnt, StallF, exp_cnt);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (StallCnt !== exp_cnt || StallF !== 1'b0) begin
            errors++;
            $display("FAIL branch_load_end got cnt=%0d stall=%b exp cnt=%0d stall=0", StallCnt, StallF, exp_cnt);
        end
        flush_pipe();
    endtask

    task automatic test_alu_b2b;
        set_d(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (ForwardAE !== 2'd2 || ForwardBE !== 2'd0) begin
            errors++;
            $display("FAIL alu_fwd_m got AE=%0d BE=%0d exp AE=2 BE=0", ForwardAE, ForwardBE);
        end
        checks++;
        if (ForwardAD !== 1'b1 || ForwardBD !== 1'b0 || StallF !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd_ad got AD=%b BD=%b stall=%b exp 1 0 0", ForwardAD, ForwardBD, StallF);
        end
        tick();
        checks++;
        if (ForwardAE !== 2'd1 || ForwardAD !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd_w got AE=%0d AD=%b exp AE=1 AD=0", ForwardAE, ForwardAD);
        end
        flush_pipe();
        set_d(5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (ForwardBE !== 2'd2 || ForwardAE !== 2'd0 || ForwardBD !== 1'b1) begin
            errors++;
            $display("FAIL alu_fwd_b got BE=%0d AE=%0d BD=%b exp 2 0 1", ForwardBE, ForwardAE, ForwardBD);
        end
        tick();
        checks++;
        if (ForwardBE !== 2'd1) begin
            errors++;
            $display("FAIL alu_fwd_bw got %0d exp 1", ForwardBE);
        end
        flush_pipe();
    endtask

    task automatic test_mw_priority;
        set_d(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        set_d(5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (ForwardAE !== 2'd2 || ForwardBE !== 2'd2) begin
            errors++;
            $display("FAIL mw_priority got AE=%0d BE=%0d exp 2 2", ForwardAE, ForwardBE);
        end
        tick();
        checks++;
        if (ForwardAE !== 2'd1 || ForwardBE !== 2'd1) begin
            errors++;
            $display("FAIL mw_w_only got AE=%0d BE=%0d exp 1 1", ForwardAE, ForwardBE);
        end
        flush_pipe();
    endtask

    task automatic test_load_use;
        set_d(5'd0, 5'd10, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(5'd0, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111 || StallCnt !== exp_cnt) begin
            errors++;
            $display("FAIL load_use_stall got %b cnt=%0d exp 111 cnt=%0d", {StallF, StallD, FlushE}, StallCnt, exp_cnt);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000 || StallCnt !== exp_cnt) begin
            errors++;
            $display("FAIL load_use_clear got %b cnt=%0d exp 000 cnt=%0d", {StallF, StallD, FlushE}, StallCnt, exp_cnt);
        end
        tick();
        checks++;
        if (ForwardBE !== 2'd1) begin
            errors++;
            $display("FAIL load_use_fwd got %0d exp 1", ForwardBE);
        end
        flush_pipe();
    endtask

    task automatic test_reg_zero;
        set_d(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'd0) begin
            errors++;
            $display("FAIL reg_zero got AE=%0d BE=%0d AD=%b BD=%b exp all 0", ForwardAE, ForwardBE, ForwardAD, ForwardBD);
        end
        flush_pipe();
    endtask

    task automatic test_branch;
        set_d(5'd0, 5'd11, 5'd11, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (StallF !== 1'b1) begin
            errors++;
            $display("FAIL br_load_stall1 got %b exp 1", StallF);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (StallF !== 1'b1 || StallCnt !== exp_cnt) begin
            errors++;
            $display("FAIL br_load_stall2 got stall=%b cnt=%0d exp 1 cnt=%0d", StallF, StallCnt, exp_cnt);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (StallF !== 1'b0 || ForwardAD !== 1'b0 || StallCnt !== exp_cnt) begin
            errors++;
            $display("FAIL br_load_done got stall=%b AD=%b cnt=%0d exp 0 0 cnt=%0d", StallF, ForwardAD, StallCnt, exp_cnt);
        end
        flush_pipe();
        set_d(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (StallF !== 1'b1) begin
            errors++;
            $display("FAIL br_alu_stall got %b exp 1", StallF);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (StallF !== 1'b0 || ForwardAD !== 1'b1 || StallCnt !== exp_cnt) begin
            errors++;
            $display("FAIL br_alu_done got stall=%b AD=%b cnt=%0d exp 0 1 cnt=%0d", StallF, ForwardAD, StallCnt, exp_cnt);
        end
        flush_pipe();
    endtask

    task automatic test_saturation;
        int n;
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // Pinning the load flag with r0 operands keeps the stall asserted every cycle.
        force dut.r_MemtoRegE = 1'b1;
        #1;
        n = 16'hFFFE - int'(exp_cnt);
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (StallCnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre got %0h exp fffe", StallCnt);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (StallCnt !== 16'hFFFF || StallF !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0h stall=%b exp ffff 1", StallCnt, StallF);
        end
        #2;
        set_d(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        release dut.r_MemtoRegE;
        rst_n = 1'b0;
        #1;
        checks++;
        if (StallCnt !== 16'd0) begin
            errors++;
            $display("FAIL async_rst_cnt got %0h exp 0", StallCnt);
        end
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE} !== 9'd0) begin
            errors++;
            $display("FAIL async_rst_out got %b exp 0",
                     {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE});
        end
        tick();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 16'd0;
        rst_n   = 1'b0;
        RsD = 5'd0; RtD = 5'd0; WriteRegD = 5'd0;
        RegWriteD = 1'b0; MemtoRegD = 1'b0; BranchD = 1'b0;
        test_reset();
        test_alu_b2b();
        test_mw_priority();
        test_load_use();
        test_reg_zero();
        test_branch();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
